// File: rtl/thread_pkg.sv
// ----------------------------------------------------------------------------
// thread_pkg
// Shared types for the per-thread control path: sequencer state encoding,
// default PC width and the PC type.
// No ports (package).
// ----------------------------------------------------------------------------
package thread_pkg;

  localparam int AW = 10;

  typedef logic [AW-1:0] pc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_t;

endpackage : thread_pkg

// File: rtl/thread_sequencer_if.sv
// ----------------------------------------------------------------------------
// thread_sequencer_if
// Bundles the decoder-to-sequencer control fields and the sequencer-to-fetch
// outputs of one thread.
//   master : decode/fetch side (drives decoder fields, receives fetch control)
//   slave  : sequencer side
// Signals:
//   dec_valid, stall, is_jump, pop, set_tos, is_halted : decoder control bits
//   jump_addr, addr_tos                                : decoder targets
//   pc, fetch_en, flush                                : fetch control
// ----------------------------------------------------------------------------
interface thread_sequencer_if #(
  parameter int AW = thread_pkg::AW
);

  logic          dec_valid;
  logic          stall;
  logic          is_jump;
  logic          pop;
  logic          set_tos;
  logic          is_halted;
  logic [AW-1:0] jump_addr;
  logic [AW-1:0] addr_tos;
  logic [AW-1:0] pc;
  logic          fetch_en;
  logic          flush;

  modport master (
    output dec_valid, stall, is_jump, pop, set_tos, is_halted,
    output jump_addr, addr_tos,
    input  pc, fetch_en, flush
  );

  modport slave (
    input  dec_valid, stall, is_jump, pop, set_tos, is_halted,
    input  jump_addr, addr_tos,
    output pc, fetch_en, flush
  );

endinterface : thread_sequencer_if

// File: rtl/ret_stack.sv
// ----------------------------------------------------------------------------
// ret_stack
// Register-based LIFO of DEPTH entries, AW bits each, with zero read latency.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (empties the stack)
//   i_clr     : synchronous clear (empties the stack)
//   i_push    : write i_data on top (ignored when full)
//   i_pop     : discard top entry (ignored when empty)
//   i_data    : push data
//   o_tos     : top-of-stack, valid whenever o_empty is low
//   o_full, o_empty, o_depth : occupancy status
// ----------------------------------------------------------------------------
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [AW-1:0]            i_data,
  output logic [AW-1:0]            o_tos,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_depth
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;

  logic [AW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_ptr;
  logic [PW-1:0] w_wr_idx;
  logic [PW-1:0] w_top_idx;

  // r_ptr counts occupied entries, so its low bits address the next free slot
  // and the slot below it is the top of stack.
  assign w_wr_idx  = r_ptr[PW-1:0];
  assign w_top_idx = w_wr_idx - 1'b1;

  assign o_full  = (r_ptr == DW'(DEPTH));
  assign o_empty = (r_ptr == '0);
  assign o_depth = r_ptr;
  assign o_tos   = r_mem[w_top_idx];

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_ptr <= '0;
    end else if (i_push && !o_full) begin
      r_ptr <= r_ptr + 1'b1;
    end else if (i_pop && !o_empty) begin
      r_ptr <= r_ptr - 1'b1;
    end
  end

  // Entry storage carries no reset; only the pointer decides what is valid.
  always_ff @(posedge clk) begin
    if (i_push && !o_full) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

endmodule : ret_stack

// File: rtl/thread_sequencer.sv
// ----------------------------------------------------------------------------
// thread_sequencer
// PC and control-flow sequencer for one thread: owns the PC, a hardware
// return/loop stack, and the IDLE/RUN/HALT thread state.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_start       : launch thread (honoured in IDLE or HALT only)
//   i_start_pc    : first fetch address, sampled with i_start
//   bus (slave)   : decoder fields in; pc / fetch_en / flush out
//   o_running     : state is RUN
//   o_halted      : state is HALT
//   o_err         : sticky stack overflow/underflow, cleared by start or rst
//   o_depth       : current stack occupancy
// ----------------------------------------------------------------------------
module thread_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = thread_pkg::AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [AW-1:0]          i_start_pc,
  thread_sequencer_if.slave      bus,
  output logic                   o_running,
  output logic                   o_halted,
  output logic                   o_err,
  output logic [$clog2(DEPTH):0] o_depth
);

  import thread_pkg::*;

  seq_state_t    r_state;
  seq_state_t    w_state_nxt;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_nxt;
  logic          r_err;
  logic          w_err_nxt;

  logic          w_start;
  logic          w_retire;
  logic          w_do_halt;
  logic          w_do_pop;
  logic          w_pop_err;
  logic          w_do_jump;
  logic          w_do_push;
  logic          w_push_err;
  logic          w_do_seq;
  logic          w_fetch_en;
  logic          w_flush;

  logic [AW-1:0] w_tos;
  logic          w_full;
  logic          w_empty;

  ret_stack #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ret_stack (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_start),
    .i_push  (w_do_push),
    .i_pop   (w_do_pop),
    .i_data  (bus.addr_tos),
    .o_tos   (w_tos),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_depth (o_depth)
  );

  // Retire priority encoder. Exactly one action fires per retired
  // instruction, so push and pop can never coincide. A cycle with rst high
  // retires nothing, which also keeps flush low during reset.
  always_comb begin
    w_start    = i_start && (r_state != RUN);
    w_retire   = (r_state == RUN) && bus.dec_valid && !bus.stall && !rst;
    w_do_halt  = 1'b0;
    w_do_pop   = 1'b0;
    w_pop_err  = 1'b0;
    w_do_jump  = 1'b0;
    w_do_push  = 1'b0;
    w_push_err = 1'b0;
    w_do_seq   = 1'b0;
    if (w_retire) begin
      if (bus.is_halted) begin
        w_do_halt = 1'b1;
      end else if (bus.pop) begin
        if (w_empty) w_pop_err = 1'b1;
        else         w_do_pop  = 1'b1;
      end else if (bus.is_jump) begin
        w_do_jump = 1'b1;
      end else if (bus.set_tos) begin
        if (w_full) w_push_err = 1'b1;
        else        w_do_push  = 1'b1;
      end else begin
        w_do_seq = 1'b1;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, HALT: begin
        if (w_start) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_do_halt || w_pop_err || w_push_err) w_state_nxt = HALT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM: outputs (decodes of the registered state)
  always_comb begin
    o_running  = (r_state == RUN);
    o_halted   = (r_state == HALT);
    w_fetch_en = o_running && !bus.stall;
    w_flush    = w_do_pop || w_do_jump;
  end

  // PC and sticky error next values. Faulting retires leave the PC alone so
  // it still points at the offending instruction's successor fetch.
  always_comb begin
    w_pc_nxt  = r_pc;
    w_err_nxt = r_err;
    if (w_start) begin
      w_pc_nxt  = i_start_pc;
      w_err_nxt = 1'b0;
    end else begin
      if (w_do_pop)                      w_pc_nxt = w_tos;
      else if (w_do_jump)                w_pc_nxt = bus.jump_addr;
      else if (w_do_push || w_do_seq)    w_pc_nxt = r_pc + 1'b1;
      if (w_pop_err || w_push_err)       w_err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= '0;
      r_err <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_err <= w_err_nxt;
    end
  end

  assign bus.pc       = r_pc;
  assign bus.fetch_en = w_fetch_en;
  assign bus.flush    = w_flush;
  assign o_err        = r_err;

endmodule : thread_sequencer

// File: tb/tb_thread_sequencer.sv
// ----------------------------------------------------------------------------
// tb_thread_sequencer
// Directed stimulus against thread_sequencer with a queue-based reference
// model of the thread (state, PC, stack, error) compared every cycle, plus
// literal expectations at key points of each scenario.
// ----------------------------------------------------------------------------
module tb_thread_sequencer;

  localparam int DEPTH = 4;
  localparam int AW    = 10;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_pc;
  logic          running;
  logic          halted;
  logic          err;
  logic [2:0]    depth;

  thread_sequencer_if #(.AW(AW)) bus ();

  thread_sequencer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (start),
    .i_start_pc (start_pc),
    .bus        (bus),
    .o_running  (running),
    .o_halted   (halted),
    .o_err      (err),
    .o_depth    (depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_state: 0 = idle, 1 = run, 2 = halt
  int m_state = 0;
  int m_pc    = 0;
  int m_err   = 0;
  int m_stack[$];
  bit m_live  = 1'b0;

  function automatic bit model_retire();
    return (m_state == 1) && bus.dec_valid && !bus.stall && !rst;
  endfunction

  function automatic bit model_flush();
    if (!model_retire() || bus.is_halted) return 1'b0;
    if (bus.pop) return (m_stack.size() > 0);
    return bus.is_jump;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0;
      m_pc    = 0;
      m_err   = 0;
      m_stack.delete();
      m_live  = 1'b1;
    end else if (start && m_state != 1) begin
      m_state = 1;
      m_pc    = int'(start_pc);
      m_err   = 0;
      m_stack.delete();
    end else if (model_retire()) begin
      if (bus.is_halted) begin
        m_state = 2;
      end else if (bus.pop) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin m_err = 1; m_state = 2; end
      end else if (bus.is_jump) begin
        m_pc = int'(bus.jump_addr);
      end else if (bus.set_tos) begin
        if (m_stack.size() < DEPTH) begin
          m_stack.push_back(int'(bus.addr_tos));
          m_pc = (m_pc + 1) % (1 << AW);
        end else begin
          m_err = 1; m_state = 2;
        end
      end else begin
        m_pc = (m_pc + 1) % (1 << AW);
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("pc",       32'(bus.pc),       32'(m_pc));
      check("fetch_en", 32'(bus.fetch_en), 32'((m_state == 1) && !bus.stall));
      check("flush",    32'(bus.flush),    32'(model_flush()));
      check("running",  32'(running),      32'(m_state == 1));
      check("halted",   32'(halted),       32'(m_state == 2));
      check("err",      32'(err),          32'(m_err));
      check("depth",    32'(depth),        32'(m_stack.size()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_dec();
    bus.dec_valid = 1'b0;
    bus.stall     = 1'b0;
    bus.is_jump   = 1'b0;
    bus.pop       = 1'b0;
    bus.set_tos   = 1'b0;
    bus.is_halted = 1'b0;
    bus.jump_addr = '0;
    bus.addr_tos  = '0;
  endtask

  task automatic do_start(input logic [AW-1:0] spc);
    clear_dec();
    start    = 1'b1;
    start_pc = spc;
    step();
    start    = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    start_pc = '0;
    clear_dec();
    step();
    step();
    check("lit_rst_pc",      32'(bus.pc),       32'h0);
    check("lit_rst_running", 32'(running),      32'h0);
    check("lit_rst_fetch",   32'(bus.fetch_en), 32'h0);
    check("lit_rst_err",     32'(err),          32'h0);
    rst = 1'b0;
    step();

    // Start and three plain retires
    do_start(10'h010);
    check("lit_start_running", 32'(running), 32'h1);
    check("lit_start_pc",      32'(bus.pc),  32'h010);
    bus.dec_valid = 1'b1;
    step(); check("lit_seq_pc1", 32'(bus.pc), 32'h011);
    step(); check("lit_seq_pc2", 32'(bus.pc), 32'h012);
    step(); check("lit_seq_pc3", 32'(bus.pc), 32'h013);

    // Jump held off by stall, then taken
    bus.is_jump   = 1'b1;
    bus.jump_addr = 10'h200;
    bus.stall     = 1'b1;
    #1 check("lit_stall_flush", 32'(bus.flush), 32'h0);
    step(); step();
    check("lit_stall_pc", 32'(bus.pc), 32'h013);
    bus.stall = 1'b0;
    #1 check("lit_jump_flush", 32'(bus.flush), 32'h1);
    step();
    clear_dec();
    check("lit_jump_pc", 32'(bus.pc), 32'h200);

    // Stack round trip from 0x020
    bus.dec_valid = 1'b1; bus.is_jump = 1'b1; bus.jump_addr = 10'h020;
    step();
    clear_dec();
    bus.dec_valid = 1'b1; bus.set_tos = 1'b1; bus.addr_tos = 10'h100;
    step();
    check("lit_push_depth", 32'(depth), 32'h1);
    bus.set_tos = 1'b0;
    step(); step();
    check("lit_seq_after_push", 32'(bus.pc), 32'h023);
    bus.pop = 1'b1;
    #1 check("lit_pop_flush", 32'(bus.flush), 32'h1);
    step();
    clear_dec();
    check("lit_pop_pc",    32'(bus.pc), 32'h100);
    check("lit_pop_depth", 32'(depth),  32'h0);

    // Overflow: five pushes
    bus.dec_valid = 1'b1; bus.set_tos = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.addr_tos = AW'(10'h300 + i);
      step();
    end
    check("lit_full_depth", 32'(depth), 32'h4);
    step();
    clear_dec();
    check("lit_ovf_err",   32'(err),          32'h1);
    check("lit_ovf_halt",  32'(halted),       32'h1);
    check("lit_ovf_fetch", 32'(bus.fetch_en), 32'h0);
    do_start(10'h050);
    check("lit_restart_err",   32'(err),   32'h0);
    check("lit_restart_depth", 32'(depth), 32'h0);

    // Underflow
    bus.dec_valid = 1'b1; bus.pop = 1'b1;
    step();
    clear_dec();
    check("lit_unf_err",  32'(err),    32'h1);
    check("lit_unf_halt", 32'(halted), 32'h1);

    // Halt wins over pop with two entries stacked
    do_start(10'h060);
    bus.dec_valid = 1'b1; bus.set_tos = 1'b1; bus.addr_tos = 10'h111;
    step();
    bus.addr_tos = 10'h222;
    step();
    bus.set_tos = 1'b0; bus.pop = 1'b1; bus.is_halted = 1'b1;
    #1 check("lit_hp_flush", 32'(bus.flush), 32'h0);
    step();
    clear_dec();
    check("lit_hp_halt",  32'(halted), 32'h1);
    check("lit_hp_depth", 32'(depth),  32'h2);
    check("lit_hp_err",   32'(err),    32'h0);

    // PC wrap, start ignored in RUN, reset mid-run
    do_start(10'h3FE);
    bus.dec_valid = 1'b1;
    step(); check("lit_wrap1", 32'(bus.pc), 32'h3FF);
    step(); check("lit_wrap2", 32'(bus.pc), 32'h000);
    step(); check("lit_wrap3", 32'(bus.pc), 32'h001);
    clear_dec();
    start = 1'b1; start_pc = 10'h155;
    step();
    start = 1'b0;
    check("lit_start_in_run", 32'(bus.pc), 32'h001);
    bus.dec_valid = 1'b1; bus.is_jump = 1'b1; bus.jump_addr = 10'h2AA;
    rst = 1'b1;
    #1 check("lit_rst_flush", 32'(bus.flush), 32'h0);
    step();
    check("lit_mid_rst_pc",      32'(bus.pc),  32'h0);
    check("lit_mid_rst_running", 32'(running), 32'h0);
    check("lit_mid_rst_depth",   32'(depth),   32'h0);
    rst = 1'b0;
    clear_dec();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_thread_sequencer

// File: doc/thread_sequencer.md
# thread_sequencer

Program-counter and control-flow sequencer for one thread. Consumes the control fields from the thread's instruction decoder (jump, pop, set-TOS, halt, 10-bit target addresses), owns the 10-bit PC and a small hardware return/loop stack, and drives the instruction-fetch address. It also sequences thread start, halt and error states, and tells the fetch/decode stage when to flush a wrong-path instruction.

## Interface
- `DEPTH`, 4: return-stack entries (power of two, ≥2).
- `AW`, 10: PC / target address width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  launch thread; accepted only in IDLE or HALT.
- `start_pc`  in  AW  first fetch address, sampled with `start`.
- `dec_valid`  in  1  decoded instruction present this cycle.
- `stall`  in  1  downstream backpressure; blocks instruction retirement.
- `is_jump`, `pop`, `set_tos`, `is_halted`  in  1 each  decoder control bits.
- `jump_addr`, `addr_tos`  in  AW  decoder target fields.
- `pc`  out  AW  current fetch address.
- `fetch_en`  out  1  fetch at `pc` this cycle.
- `flush`  out  1  one-cycle pulse: discard the in-flight fetched instruction.
- `running`, `halted`  out  1  state indicators.
- `err`  out  1  sticky stack fault (overflow/underflow); cleared by `start` or `rst`.
- `depth`  out  $clog2(DEPTH)+1  current stack occupancy.

## Operation
- States: IDLE, RUN, HALT.
- IDLE: `start` -> RUN, `pc`<=`start_pc`, stack emptied, `err`<=0.
- RUN: an instruction retires when `dec_valid & ~stall`. If nothing retires, all state holds.
- Retire priority: `is_halted` > `pop` > `is_jump` > `set_tos` > sequential. `is_halted` may arrive together with `pop`; halt wins, and the stack is untouched.
  - `is_halted`: -> HALT. `pc` holds.
  - `pop`, stack non-empty: `pc`<=TOS, depth-1, `flush`=1.
  - `pop`, stack empty: `err`<=1, -> HALT, `pc` holds.
  - `is_jump`: `pc`<=`jump_addr`, `flush`=1.
  - `set_tos`, stack not full: push `addr_tos`, `pc`<=`pc`+1.
  - `set_tos`, stack full: `err`<=1, -> HALT, no push.
  - None of the above: `pc`<=`pc`+1.
- `pc`+1 wraps from 2^AW-1 to 0 with no fault.
- HALT: `fetch_en`=0. Only `start` leaves this state; it behaves exactly as from IDLE.
- `start` while in RUN is ignored.
- `flush` is asserted only on a taken redirect (jump or successful pop) and never in IDLE or HALT.

## Timing
- Reset values: state=IDLE, `pc`=0, `depth`=0, `fetch_en`=0, `flush`=0, `running`=0, `halted`=0, `err`=0.
- `running` = (state==RUN). `halted` = (state==HALT). Both are registered state decodes.
- `fetch_en` = running & ~stall.
- Instruction memory has 1-cycle latency, so the instruction fetched at `pc` in cycle n is the one presented with `dec_valid` in cycle n+1.
- Redirect penalty is one bubble. `flush` is combinational in the retire cycle, and upstream must drop the instruction arriving in the next cycle.
- Start latency: `start` in cycle n gives `running`=1 and `pc`=`start_pc` in cycle n+1, with the first fetch in cycle n+1.
- Push and pop never coincide (priority encoder), so stack pointer updates are single-action.
- `rst` mid-RUN clears everything in the next cycle. No instruction retires in a cycle where `rst`=1.

## Structure
- Shared thread package `thread_pkg`:
  - `seq_state_t` enum {IDLE, RUN, HALT}.
  - `AW` default constant.
  - `pc_t` typedef (logic [AW-1:0]).
- Sub-module `ret_stack`: LIFO of `DEPTH`×`AW` with `push`/`pop`/`tos`/`full`/`empty`/`depth`. It is register-based and has no read latency. `tos` is valid whenever the stack is non-empty.
- Top level contains the FSM, PC register, retire-priority logic and `err` flag.

## Test plan
- Reset/start: assert `rst`, then `start` with `start_pc`=0x010 and 3 plain retires -> `pc` = 0x010, 0x011, 0x012, 0x013. `running`=1 from the cycle after `start`.
- Jump and stall:
  - `is_jump` with `jump_addr`=0x200 and `stall`=1 for 2 cycles -> `pc` holds and `flush`=0.
  - When `stall` drops -> `flush` pulses once and `pc`=0x200 in the next cycle.
- Stack round-trip: from `pc`=0x020, `set_tos` with `addr_tos`=0x100, then 2 plain retires, then `pop` -> `depth` goes 1 then 0, `pc`=0x100 after the pop, and `flush`=1 in the pop cycle.
- Overflow (DEPTH=4): 5 consecutive `set_tos` -> 4th push gives `depth`=4. The 5th sets `err`=1 and enters HALT with `fetch_en`=0. A subsequent `start` clears `err` and empties the stack.
- Underflow and halt priority:
  - `pop` on an empty stack -> `err`=1, HALT.
  - Separately, `is_halted`&`pop` with `depth`=2 -> HALT, `depth` stays 2, `err`=0.
- Wrap and reset mid-run: start at 0x3FE with 3 retires -> `pc` = 0x3FF, 0x000, 0x001. Then `rst` during RUN -> all outputs return to their reset values next cycle.
